mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_access_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/memory bus bundle for mem_access_ctrl.
// The slave modport is the controller's view; master is the datapath/memory side.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic [15:0] rdata;
  logic        rdata_odd;
  logic        done;
  logic        err;

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, mem_resp, mem_rdata,
    output req_ready, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
           rdata, rdata_odd, done, err
  );

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, mem_resp, mem_rdata,
    input  req_ready, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
           rdata, rdata_odd, done, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3b style memory access controller: IDLE -> ACCESS -> DONE with alignment error.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        byte_q,  byte_d;
  logic [15:0] addr_q,  addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        odd_q,   odd_d;
  logic        err_q,   err_d;
  logic        timeout_hit;
  logic        in_access;

  assign in_access = (state_q == ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter sits at zero outside ACCESS, so it is clear on every entry.
  assign cnt_d       = in_access ? cnt_q + CNT_W'(1) : '0;
  assign timeout_hit = in_access && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      odd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      odd_q   <= odd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    odd_d   = odd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          byte_d  = bus.req_byte;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          // Odd word address never reaches memory; report it straight away.
          err_d   = !bus.req_byte && bus.req_addr[0];
          state_d = (!bus.req_byte && bus.req_addr[0]) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_resp) begin
          if (!write_q) begin
            rdata_d = bus.mem_rdata;
            odd_d   = addr_q[0];
          end
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_byte_enable = 2'b00;
    if (in_access && write_q) begin
      if (!byte_q)        bus.mem_byte_enable = 2'b11;
      else if (addr_q[0]) bus.mem_byte_enable = 2'b10;
      else                bus.mem_byte_enable = 2'b01;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.mem_read    = in_access && !write_q;
  assign bus.mem_write   = in_access && write_q;
  assign bus.mem_address = addr_q;
  // Byte stores replicate the low byte so either lane carries it.
  assign bus.mem_wdata   = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_odd   = odd_q;
  assign bus.done        = (state_q == DONE) && !err_q;
  assign bus.err         = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (timeout case when MEM_TIMEOUT_EN is defined).
module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_byte  = b;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
    check({tag, "_rd"},    32'(bus.mem_read), 32'h0);
    check({tag, "_wr"},    32'(bus.mem_write), 32'h0);
    check({tag, "_addr"},  32'(bus.mem_address), 32'h0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'h0);
    check({tag, "_be"},    32'(bus.mem_byte_enable), 32'h0);
    check({tag, "_rdata"}, 32'(bus.rdata), 32'h0);
    check({tag, "_odd"},   32'(bus.rdata_odd), 32'h0);
    check({tag, "_done"},  32'(bus.done), 32'h0);
    check({tag, "_err"},   32'(bus.err), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Word load 0x1000, resp in third ACCESS cycle; a stray request mid-access is ignored.
    start(1'b0, 1'b0, 16'h1000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      check("ld_rd", 32'(bus.mem_read), 32'h1);
      check("ld_wr", 32'(bus.mem_write), 32'h0);
      check("ld_addr", 32'(bus.mem_address), 32'h1000);
      check("ld_be", 32'(bus.mem_byte_enable), 32'h0);
      check("ld_ready", 32'(bus.req_ready), 32'h0);
      check("ld_done_early", 32'(bus.done), 32'h0);
      if (i == 0) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'hAAAA;
      end
      if (i == 2) begin
        bus.req_valid = 1'b0;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 16'hBEEF;
      end
      tick();
    end
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 16'h0000;
    check("ld_done", 32'(bus.done), 32'h1);
    check("ld_err", 32'(bus.err), 32'h0);
    check("ld_rd_drop", 32'(bus.mem_read), 32'h0);
    check("ld_rdata", 32'(bus.rdata), 32'hBEEF);
    check("ld_odd", 32'(bus.rdata_odd), 32'h0);
    tick();
    check("ld_done_once", 32'(bus.done), 32'h0);
    check("ld_idle", 32'(bus.req_ready), 32'h1);

    // Byte store to odd address: high lane, replicated data.
    start(1'b1, 1'b1, 16'h2001, 16'h12A5);
    for (int i = 0; i < 2; i++) begin
      check("stb_wr", 32'(bus.mem_write), 32'h1);
      check("stb_rd", 32'(bus.mem_read), 32'h0);
      check("stb_wdata", 32'(bus.mem_wdata), 32'hA5A5);
      check("stb_be", 32'(bus.mem_byte_enable), 32'h2);
      check("stb_addr", 32'(bus.mem_address), 32'h2001);
      if (i == 1) bus.mem_resp = 1'b1;
      tick();
    end
    bus.mem_resp = 1'b0;
    check("stb_done", 32'(bus.done), 32'h1);
    check("stb_wr_drop", 32'(bus.mem_write), 32'h0);
    check("stb_rdata", 32'(bus.rdata), 32'hBEEF);
    tick();

    // Byte store to even address: low lane, same-cycle response.
    start(1'b1, 1'b1, 16'h2000, 16'hFF33);
    check("stb0_wdata", 32'(bus.mem_wdata), 32'h3333);
    check("stb0_be", 32'(bus.mem_byte_enable), 32'h1);
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    check("stb0_done", 32'(bus.done), 32'h1);
    tick();

    // Word store: both lanes, data unchanged.
    start(1'b1, 1'b0, 16'h4000, 16'h1234);
    check("stw_wdata", 32'(bus.mem_wdata), 32'h1234);
    check("stw_be", 32'(bus.mem_byte_enable), 32'h3);
    check("stw_wr", 32'(bus.mem_write), 32'h1);
    bus.mem_resp = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    check("stw_done", 32'(bus.done), 32'h1);
    check("stw_rdata", 32'(bus.rdata), 32'hBEEF);
    tick();

    // Byte load from odd address fetches the full word and records the odd flag.
    start(1'b0, 1'b1, 16'h5003, 16'h0000);
    check("ldb_rd", 32'(bus.mem_read), 32'h1);
    check("ldb_be", 32'(bus.mem_byte_enable), 32'h0);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 16'h7788;
    tick();
    bus.mem_resp  = 1'b0;
    check("ldb_done", 32'(bus.done), 32'h1);
    check("ldb_rdata", 32'(bus.rdata), 32'h7788);
    check("ldb_odd", 32'(bus.rdata_odd), 32'h1);
    tick();

    // Misaligned word load: error pulse, no strobes, load result untouched.
    start(1'b0, 1'b0, 16'h3003, 16'h0000);
    check("mis_err", 32'(bus.err), 32'h1);
    check("mis_done", 32'(bus.done), 32'h0);
    check("mis_rd", 32'(bus.mem_read), 32'h0);
    check("mis_wr", 32'(bus.mem_write), 32'h0);
    check("mis_rdata", 32'(bus.rdata), 32'h7788);
    check("mis_odd", 32'(bus.rdata_odd), 32'h1);
    tick();
    check("mis_err_once", 32'(bus.err), 32'h0);
    check("mis_idle", 32'(bus.req_ready), 32'h1);

    // Misaligned word store also errors without a write strobe.
    start(1'b1, 1'b0, 16'h3005, 16'hDEAD);
    check("miss_err", 32'(bus.err), 32'h1);
    check("miss_wr", 32'(bus.mem_write), 32'h0);
    tick();

    // mem_resp in IDLE must not complete anything.
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    tick();
    bus.mem_resp  = 1'b0;
    check("idle_resp_done", 32'(bus.done), 32'h0);
    check("idle_resp_rdata", 32'(bus.rdata), 32'h7788);
    check("idle_resp_ready", 32'(bus.req_ready), 32'h1);

    // Reset during ACCESS abandons the load; its late response is ignored.
    start(1'b0, 1'b0, 16'h6000, 16'h0000);
    check("rsta_rd", 32'(bus.mem_read), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rsta");
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 16'h1111;
    tick();
    bus.mem_resp  = 1'b0;
    check_reset_outputs("rstb");
    tick();
    check("rstc_done", 32'(bus.done), 32'h0);
    check("rstc_err", 32'(bus.err), 32'h0);

`ifdef MEM_TIMEOUT_EN
    // No response: strobe for four cycles then error, rdata kept.
    start(1'b0, 1'b0, 16'h7000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      check("to_rd", 32'(bus.mem_read), 32'h1);
      check("to_err_early", 32'(bus.err), 32'h0);
      tick();
    end
    check("to_err", 32'(bus.err), 32'h1);
    check("to_done", 32'(bus.done), 32'h0);
    check("to_rd_drop", 32'(bus.mem_read), 32'h0);
    check("to_rdata", 32'(bus.rdata), 32'h0);
    tick();
    check("to_idle", 32'(bus.req_ready), 32'h1);
`else
    // Without the watchdog the access waits as long as memory takes.
    start(1'b0, 1'b0, 16'h7000, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      check("wait_rd", 32'(bus.mem_read), 32'h1);
      check("wait_err", 32'(bus.err), 32'h0);
      tick();
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 16'h2222;
    tick();
    bus.mem_resp  = 1'b0;
    check("wait_done", 32'(bus.done), 32'h1);
    check("wait_rdata", 32'(bus.rdata), 32'h2222);
    tick();
    check("wait_idle", 32'(bus.req_ready), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
